punctured_transmitter: RTL and testbench

PUNCTURED_TRANSMITTER -- requirements
Module: punctured_transmitter

---
 rtl/punctured_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_punctured_transmitter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/punctured_transmitter.sv
// Punctured convolutional transmitter: scrambles a data frame, appends a zero
// tail and scrambled pad, encodes each bit with a K=7 rate-1/2 code and
// punctures the coded pairs down to rate 1/2, 2/3 or 3/4.
module punctured_transmitter #(
  parameter int         LEN_W    = 16,
  parameter int         PAD_W    = 8,
  parameter int         TAIL_LEN = 6,
  parameter logic [6:0] G0       = 7'o133,
  parameter logic [6:0] G1       = 7'o171
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [PAD_W-1:0] tail_pad_length,
  input  logic [1:7]       initial_seed,
  input  logic [1:0]       rate_sel,
  input  logic             data_in,
  output logic             data_req,
  output logic             A_out,
  output logic             B_out,
  output logic             A_valid,
  output logic             B_valid,
  output logic             busy,
  output logic             done
);

  localparam int TAIL_W = $clog2(TAIL_LEN + 1);
  localparam int LP_W   = (LEN_W > PAD_W) ? LEN_W : PAD_W;
  localparam int CNT_W  = (LP_W > TAIL_W) ? LP_W : TAIL_W;

  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    PAD  = 2'd3
  } state_t;

  state_t state, state_next;

  // Per-frame configuration captured when start is accepted.
  logic [LEN_W-1:0] len_q;
  logic [PAD_W-1:0] pad_q;
  logic [1:0]       rate_q;

  logic [1:7]       sr;       // scrambler shift register
  logic [5:0]       hist;     // encoder history: hist[5] = e0 (newest) .. hist[0] = e5
  logic [1:0]       phase;    // puncture phase
  logic [CNT_W-1:0] cnt;      // bits processed in the current state

  logic [CNT_W-1:0] len_last;
  logic [CNT_W-1:0] pad_last;
  logic             fb;
  logic             enc_bit;
  logic             active;
  logic             scr_adv;
  logic             last_bit;
  logic             punct_a;
  logic             punct_b;
  logic             phase_last;
  logic             accept;

  assign len_last = CNT_W'(len_q) - CNT_W'(1);
  assign pad_last = CNT_W'(pad_q) - CNT_W'(1);
  assign fb       = sr[4] ^ sr[7];
  assign accept   = (state == IDLE) && start;
  assign busy     = (state != IDLE) || done;

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-cycle bit source selection.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    data_req   = 1'b0;
    enc_bit    = 1'b0;
    active     = 1'b0;
    scr_adv    = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (frame_len != '0) ? DATA : TAIL;
      end
      DATA: begin
        data_req = 1'b1;
        active   = 1'b1;
        scr_adv  = 1'b1;
        enc_bit  = data_in ^ fb;
        if (cnt == len_last) state_next = TAIL;
      end
      TAIL: begin
        active = 1'b1;
        if (cnt == TAIL_LAST) begin
          if (pad_q != '0) begin
            state_next = PAD;
          end else begin
            state_next = IDLE;
            last_bit   = 1'b1;
          end
        end
      end
      PAD: begin
        active  = 1'b1;
        scr_adv = 1'b1;
        enc_bit = fb;  // pad input is zero, so the scrambled bit is the feedback
        if (cnt == pad_last) begin
          state_next = IDLE;
          last_bit   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Puncture pattern lookup for the current phase.
  always_comb begin
    punct_a    = 1'b1;
    punct_b    = 1'b1;
    phase_last = 1'b1;
    case (rate_q)
      2'd1: begin
        punct_b    = (phase == 2'd0);
        phase_last = (phase == 2'd1);
      end
      2'd2: begin
        punct_a    = (phase != 2'd2);
        punct_b    = (phase != 2'd1);
        phase_last = (phase == 2'd2);
      end
      default: ;
    endcase
  end

  // Datapath: configuration capture, scrambler, encoder, puncture and outputs.
  always_ff @(posedge Clk) begin
    // NOTE: reset wins over start; all state and outputs clear so an aborted frame never signals done.
    if (reset) begin
      len_q   <= '0;
      pad_q   <= '0;
      rate_q  <= '0;
      sr      <= '0;
      hist    <= '0;
      phase   <= '0;
      cnt     <= '0;
      A_out   <= 1'b0;
      B_out   <= 1'b0;
      A_valid <= 1'b0;
      B_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      A_valid <= 1'b0;
      B_valid <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        len_q  <= frame_len;
        pad_q  <= tail_pad_length;
        rate_q <= rate_sel;
        sr     <= initial_seed;
        hist   <= '0;
        phase  <= '0;
        cnt    <= '0;
      end else if (active) begin
        A_out   <= ^(G0 & {enc_bit, hist});
        B_out   <= ^(G1 & {enc_bit, hist});
        A_valid <= punct_a;
        B_valid <= punct_b;
        done    <= last_bit;
        hist    <= {enc_bit, hist[5:1]};
        if (scr_adv) sr <= {fb, sr[1:6]};
        phase   <= phase_last ? 2'd0 : phase + 2'd1;
        cnt     <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_punctured_transmitter.sv
// Directed self-checking bench for punctured_transmitter.
module tb_punctured_transmitter;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  tail_pad_length = '0;
  logic [1:7]  initial_seed = '0;
  logic [1:0]  rate_sel = '0;
  logic        data_in = 1'b0;
  logic        data_req, A_out, B_out, A_valid, B_valid, busy, done;

  punctured_transmitter dut (
    .Clk             (Clk),
    .reset           (reset),
    .start           (start),
    .frame_len       (frame_len),
    .tail_pad_length (tail_pad_length),
    .initial_seed    (initial_seed),
    .rate_sel        (rate_sel),
    .data_in         (data_in),
    .data_req        (data_req),
    .A_out           (A_out),
    .B_out           (B_out),
    .A_valid         (A_valid),
    .B_valid         (B_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Expected pairs from the reference model, and captured DUT pairs.
  logic ea [0:127];
  logic eb [0:127];
  logic eva[0:127];
  logic evb[0:127];
  logic ca [0:127];
  logic cb [0:127];
  int   n_exp;

  // Next-frame parameters used when a start is issued on the done cycle.
  int         nxt_len, nxt_pad;
  logic [1:7] nxt_seed;
  logic [1:0] nxt_rate;

  // Hand-derived (A,B) for seed 1011101, 4 zero data bits, rate 1/2, no pad.
  logic [1:0] basic_ab [0:9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scrambler, K=7 encoder written out as tap equations, puncture by index.
  task automatic build_model(input int len, input int pad, input logic [1:7] seed,
                             input logic [1:0] rate, input logic [63:0] data);
    logic [1:7] s;
    logic       e[0:5];
    logic       d, f;
    s = seed;
    for (int j = 0; j < 6; j++) e[j] = 1'b0;
    n_exp = len + 6 + pad;
    for (int i = 0; i < n_exp; i++) begin
      f = s[4] ^ s[7];
      if (i < len) begin
        d = data[i] ^ f;
        s = {f, s[1:6]};
      end else if (i < len + 6) begin
        d = 1'b0;
      end else begin
        d = f;
        s = {f, s[1:6]};
      end
      // 133 octal taps: d, e1, e2, e4, e5; 171 octal taps: d, e0, e1, e2, e5
      ea[i] = d ^ e[1] ^ e[2] ^ e[4] ^ e[5];
      eb[i] = d ^ e[0] ^ e[1] ^ e[2] ^ e[5];
      for (int j = 5; j > 0; j--) e[j] = e[j-1];
      e[0] = d;
      case (rate)
        2'd1:    begin eva[i] = 1'b1;        evb[i] = (i % 2 == 0); end
        2'd2:    begin eva[i] = (i % 3 != 2); evb[i] = (i % 3 != 1); end
        default: begin eva[i] = 1'b1;        evb[i] = 1'b1;        end
      endcase
    end
  endtask

  // Runs one frame cycle-by-cycle; sampling and driving happen on the falling edge.
  task automatic run_frame(input string tag, input int len, input int pad,
                           input logic [1:7] seed, input logic [1:0] rate,
                           input logic [63:0] data, input bit chained,
                           input bit chain_next, input bit poke_start);
    int nvalid;
    int bi;
    if (!chained) begin
      @(negedge Clk);
      frame_len       = 16'(len);
      tail_pad_length = 8'(pad);
      initial_seed    = seed;
      rate_sel        = rate;
      start           = 1'b1;
    end
    build_model(len, pad, seed, rate, data);
    nvalid = 0;
    bi     = 0;
    for (int k = 0; k <= n_exp; k++) begin
      @(negedge Clk);
      start = 1'b0;
      if (k == 0) begin
        check({tag, " first valid"}, {30'd0, A_valid, B_valid}, 32'd0);
      end else begin
        check({tag, " pair"}, {28'd0, A_valid, B_valid, A_out, B_out},
              {28'd0, eva[k-1], evb[k-1], ea[k-1], eb[k-1]});
        ca[k-1] = A_out;
        cb[k-1] = B_out;
        if (A_valid || B_valid) nvalid++;
      end
      check({tag, " data_req"}, {31'd0, data_req}, {31'd0, k < len});
      check({tag, " done"},     {31'd0, done},     {31'd0, k == n_exp});
      check({tag, " busy"},     {31'd0, busy},     32'd1);
      if (data_req && bi < 64) begin
        data_in = data[bi];
        bi++;
      end
      if (poke_start && k == len + 2) begin
        start     = 1'b1;
        frame_len = 16'(len + 5);
      end
      if (chain_next && k == n_exp) begin
        frame_len       = 16'(nxt_len);
        tail_pad_length = 8'(nxt_pad);
        initial_seed    = nxt_seed;
        rate_sel        = nxt_rate;
        start           = 1'b1;
      end
    end
    check({tag, " valid count"}, 32'(nvalid), 32'(n_exp));
    if (!chain_next) begin
      @(negedge Clk);
      check({tag, " idle after"}, {29'd0, busy, A_valid, B_valid}, 32'd0);
    end
  endtask

  task automatic check_basic_table(input string tag);
    for (int i = 0; i < 10; i++)
      check({tag, " hand pair"}, {30'd0, ca[i], cb[i]}, {30'd0, basic_ab[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    basic_ab = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};

    // Reset held two cycles: everything idle and zero.
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    check("reset outputs", {25'd0, data_req, A_out, B_out, A_valid, B_valid, busy, done}, 32'd0);

    // Basic rate-1/2 frame.
    run_frame("basic", 4, 0, 7'b1011101, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_basic_table("basic");

    // Rate 3/4 with pad: phase runs continuously through DATA, TAIL and PAD.
    run_frame("r34", 6, 3, 7'b1100101, 2'd2, 64'b101100, 1'b0, 1'b0, 1'b0);

    // Rate 2/3 with pad.
    run_frame("r23", 5, 2, 7'b0110011, 2'd1, 64'b10011, 1'b0, 1'b0, 1'b0);

    // rate_sel 3 behaves as rate 1/2.
    run_frame("r3", 3, 1, 7'b1111111, 2'd3, 64'b110, 1'b0, 1'b0, 1'b0);

    // Empty frame: tail only, all coded bits zero.
    run_frame("empty", 0, 0, 7'b1011101, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) check("empty zero pair", {30'd0, ca[i], cb[i]}, 32'd0);

    // Reset in the third DATA cycle aborts without done.
    @(negedge Clk);
    frame_len = 16'd4; tail_pad_length = 8'd0; initial_seed = 7'b1011101;
    rate_sel = 2'd0; data_in = 1'b0; start = 1'b1;
    @(negedge Clk); start = 1'b0;
    @(negedge Clk);
    @(negedge Clk); reset = 1'b1;
    @(negedge Clk); reset = 1'b0;
    check("midreset outputs", {25'd0, data_req, A_out, B_out, A_valid, B_valid, busy, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("midreset no done", {30'd0, done, busy}, 32'd0);
    end
    run_frame("rerun", 4, 0, 7'b1011101, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_basic_table("rerun");

    // Start pulsed during TAIL with a different length is ignored.
    run_frame("busy start", 4, 0, 7'b1011101, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    check_basic_table("busy start");

    // Start on the done cycle launches the next frame immediately.
    nxt_len = 3; nxt_pad = 2; nxt_seed = 7'b0001111; nxt_rate = 2'd2;
    run_frame("chain a", 2, 1, 7'b1010101, 2'd1, 64'b01, 1'b0, 1'b1, 1'b0);
    run_frame("chain b", 3, 2, 7'b0001111, 2'd2, 64'b011, 1'b1, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    @(negedge Clk);
    frame_len = 16'd4; reset = 1'b1; start = 1'b1;
    @(negedge Clk);
    reset = 1'b0; start = 1'b0;
    check("reset+start", {30'd0, busy, data_req}, 32'd0);
    @(negedge Clk);
    check("reset+start later", {30'd0, busy, data_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
